// File: rtl/speed_param_ctrl.sv
// Push-button controller for the clock-divider speed_param word: sync, debounce, saturating step.
// Optional auto-repeat while a faster/slower button is held: define SPEED_AUTO_REPEAT_EN.
module speed_param_ctrl #(
  parameter logic [31:0] STEP            = 32'd1000,
  parameter logic [31:0] MIN_PARAM       = 32'd0,
  parameter logic [31:0] MAX_PARAM       = 32'd1000000,
  parameter logic [31:0] DEFAULT_PARAM   = 32'd0,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 12500000
) (
  input  logic        inclk,
  input  logic        reset,
  input  logic        btn_faster,
  input  logic        btn_slower,
  input  logic        btn_default,
  output logic [31:0] speed_param,
  output logic        param_update,
  output logic        at_min,
  output logic        at_max,
  output logic        busy
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      MIN_PARAM > DEFAULT_PARAM || DEFAULT_PARAM > MAX_PARAM) begin : g_bad_params
    $error("speed_param_ctrl: inconsistent parameters");
  end

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Precomputed step bounds; SLOW_CAN_STEP guards MAX_PARAM - STEP against underflow.
  localparam logic [31:0] MIN_PLUS_STEP  = MIN_PARAM + STEP;
  localparam logic        SLOW_CAN_STEP  = (MAX_PARAM >= STEP);
  localparam logic [31:0] MAX_MINUS_STEP = SLOW_CAN_STEP ? (MAX_PARAM - STEP) : 32'd0;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, APPLY, HOLD} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_FASTER, CMD_SLOWER, CMD_DEFAULT} cmd_t;

  state_t state, state_n;
  cmd_t   cmd, cmd_n;

  // bit 2 = default, bit 1 = faster, bit 0 = slower
  logic [2:0] sync1, s_btn;
  logic       s_default, s_faster, s_slower;

  logic [DB_W-1:0] db_cnt;
  logic            db_clr, db_inc;
  logic            cmd_ld, apply, cmd_held;
  logic [31:0]     new_param;

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      s_btn <= '0;
    end else begin
      sync1 <= {btn_default, btn_faster, btn_slower};
      s_btn <= sync1;
    end
  end

  assign s_default = s_btn[2];
  assign s_faster  = s_btn[1];
  assign s_slower  = s_btn[0];

  always_comb begin
    cmd_held = 1'b0;
    case (cmd)
      CMD_FASTER:  cmd_held = s_faster;
      CMD_SLOWER:  cmd_held = s_slower;
      CMD_DEFAULT: cmd_held = s_default;
      default:     cmd_held = 1'b0;
    endcase
  end

  always_comb begin
    cmd_n = CMD_NONE;
    if (s_default)     cmd_n = CMD_DEFAULT;
    else if (s_faster) cmd_n = CMD_FASTER;
    else if (s_slower) cmd_n = CMD_SLOWER;
  end

  always_comb begin
    new_param = speed_param;
    case (cmd)
      CMD_FASTER:  new_param = (speed_param >= MIN_PLUS_STEP) ? speed_param - STEP : MIN_PARAM;
      CMD_SLOWER:  new_param = (SLOW_CAN_STEP && speed_param <= MAX_MINUS_STEP) ?
                               speed_param + STEP : MAX_PARAM;
      CMD_DEFAULT: new_param = DEFAULT_PARAM;
      default:     new_param = speed_param;
    endcase
  end

`ifdef SPEED_AUTO_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_clr, rpt_inc;

  // Counts from the APPLY cycle so successive updates are exactly REPEAT_CYCLES apart.
  always_ff @(posedge inclk or posedge reset) begin
    if (reset)        rpt_cnt <= '0;
    else if (rpt_clr) rpt_cnt <= '0;
    else if (rpt_inc) rpt_cnt <= rpt_cnt + 1'b1;
  end
`endif

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cmd_ld  = 1'b0;
    db_clr  = 1'b0;
    db_inc  = 1'b0;
    apply   = 1'b0;
`ifdef SPEED_AUTO_REPEAT_EN
    rpt_clr = 1'b0;
    rpt_inc = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|s_btn) begin
          cmd_ld  = 1'b1;
          db_clr  = 1'b1;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!cmd_held) state_n = IDLE;
        else if (db_cnt == DB_LAST) begin
          state_n = APPLY;
`ifdef SPEED_AUTO_REPEAT_EN
          rpt_clr = 1'b1;
`endif
        end else db_inc = 1'b1;
      end
      APPLY: begin
        apply   = 1'b1;
        state_n = HOLD;
`ifdef SPEED_AUTO_REPEAT_EN
        rpt_inc = 1'b1;
`endif
      end
      HOLD: begin
        if (!cmd_held) state_n = IDLE;
`ifdef SPEED_AUTO_REPEAT_EN
        else if (cmd != CMD_DEFAULT) begin
          if (rpt_cnt >= RPT_LAST) begin
            state_n = APPLY;
            rpt_clr = 1'b1;
          end else rpt_inc = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge inclk or posedge reset) begin
    if (reset)       db_cnt <= '0;
    else if (db_clr) db_cnt <= '0;
    else if (db_inc) db_cnt <= db_cnt + 1'b1;
  end

  always_ff @(posedge inclk or posedge reset) begin
    if (reset)       cmd <= CMD_NONE;
    else if (cmd_ld) cmd <= cmd_n;
  end

  // Saturated requests leave the value unchanged and so produce no pulse.
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      speed_param  <= DEFAULT_PARAM;
      param_update <= 1'b0;
    end else begin
      param_update <= apply && (new_param != speed_param);
      if (apply) speed_param <= new_param;
    end
  end

  assign at_min = (speed_param == MIN_PARAM);
  assign at_max = (speed_param == MAX_PARAM);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_speed_param_ctrl.sv
// Directed bench for speed_param_ctrl with small parameters (STEP=10, 0..50, default 20, debounce 4, repeat 8).
module tb_speed_param_ctrl;
  logic        inclk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_faster = 1'b0, btn_slower = 1'b0, btn_default = 1'b0;
  logic [31:0] speed_param;
  logic        param_update, at_min, at_max, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  always #5 inclk = ~inclk;

  speed_param_ctrl #(
    .STEP(32'd10), .MIN_PARAM(32'd0), .MAX_PARAM(32'd50), .DEFAULT_PARAM(32'd20),
    .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)
  ) dut (
    .inclk(inclk), .reset(reset),
    .btn_faster(btn_faster), .btn_slower(btn_slower), .btn_default(btn_default),
    .speed_param(speed_param), .param_update(param_update),
    .at_min(at_min), .at_max(at_max), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge inclk);
    #1;
    if (param_update === 1'b1) pulses++;
  endtask

  // Called 1ns after an edge; reset lands mid-cycle and is released before the next edge.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_param"}, speed_param, 32'd20);
    chk({tag, "_update"}, {31'd0, param_update}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_at_min"}, {31'd0, at_min}, 32'd0);
    chk({tag, "_at_max"}, {31'd0, at_max}, 32'd0);
    #3 reset = 1'b0;
  endtask

  // b = {default, faster, slower}
  task automatic press(input string tag, input logic [2:0] b, input int hold);
    int k;
    pulses = 0;
    {btn_default, btn_faster, btn_slower} = b;
    repeat (hold) tick();
    {btn_default, btn_faster, btn_slower} = 3'b000;
    k = 0;
    while (busy && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] sat_exp [4];
    int          sat_pls [4];
    sat_exp = '{32'd30, 32'd40, 32'd50, 32'd50};
    sat_pls = '{1, 1, 1, 0};

    repeat (2) @(posedge inclk);
    #1;
    do_reset("rst0");

    // Long slower press: update lands on edge 8, busy drops 3 edges after release.
    pulses = 0;
    btn_slower = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 7) begin
        chk("t1_e7_param", speed_param, 32'd20);
        chk("t1_e7_update", {31'd0, param_update}, 32'd0);
      end
      if (e == 8) begin
        chk("t1_e8_param", speed_param, 32'd30);
        chk("t1_e8_update", {31'd0, param_update}, 32'd1);
      end
    end
`ifdef SPEED_AUTO_REPEAT_EN
    chk("t1_held_param", speed_param, 32'd40);
    chk("t1_pulses", pulses, 2);
`else
    chk("t1_held_param", speed_param, 32'd30);
    chk("t1_pulses", pulses, 1);
`endif
    btn_slower = 1'b0;
    tick();
    tick();
    chk("t1_busy_e2", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_busy_e3", {31'd0, busy}, 32'd0);

    do_reset("rst1");

    // 4-cycle glitch is shorter than the debounce window.
    press("glitch", 3'b010, 4);
    chk("glitch_param", speed_param, 32'd20);
    chk("glitch_pulses", pulses, 0);

    for (int i = 0; i < 4; i++) begin
      press($sformatf("sat%0d", i), 3'b001, 10);
      chk($sformatf("sat%0d_param", i), speed_param, sat_exp[i]);
      chk($sformatf("sat%0d_pulses", i), pulses, sat_pls[i]);
      chk($sformatf("sat%0d_at_max", i), {31'd0, at_max}, (i >= 2) ? 32'd1 : 32'd0);
    end

    press("f50", 3'b010, 10);
    chk("f50_param", speed_param, 32'd40);
    chk("f50_pulses", pulses, 1);
    press("simul", 3'b110, 10);
    chk("simul_param", speed_param, 32'd20);
    chk("simul_pulses", pulses, 1);

    // Reset in the middle of a debounce must cancel the request.
    pulses = 0;
    btn_slower = 1'b1;
    repeat (5) tick();
    chk("mid_db_busy", {31'd0, busy}, 32'd1);
    btn_slower = 1'b0;
    do_reset("rst_db");
    repeat (12) tick();
    chk("mid_db_param", speed_param, 32'd20);
    chk("mid_db_pulses", pulses, 0);

`ifdef SPEED_AUTO_REPEAT_EN
    for (int i = 0; i < 3; i++) press($sformatf("up%0d", i), 3'b001, 10);
    chk("rpt_start", speed_param, 32'd50);
    pulses = 0;
    btn_faster = 1'b1;
    for (int e = 1; e <= 56; e++) begin
      tick();
      if (e % 8 == 0 && e <= 40)
        chk($sformatf("rpt_e%0d", e), speed_param, 32'(50 - 10 * (e / 8)));
      if (e == 40) chk("rpt_at_min", {31'd0, at_min}, 32'd1);
    end
    chk("rpt_pulses", pulses, 5);
    btn_faster = 1'b0;
    repeat (4) tick();
    chk("rpt_idle", {31'd0, busy}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
